simple_alu_wb_stage: RTL
========================

// Module: simple_alu_wb_stage
// PURPOSE
//   Execute->writeback pipe register for the simple-ALU lane, placed directly after the
//   combinational simple ALU. Buffers up to 2 results (result, flags, dest, AL tag,
//   branch mask) in a skid queue. Drains to the shared RF write port with a valid/ready
//   handshake and broadcasts the head entry on the bypass network. Squashes entries on a
//   CTI mispredict or an exception flush.
// PARAMETERS
//   SIZE_DATA        32  result / bypass data width
//   EXECUTION_FLAGS   6  ALU flag vector width, passed through unmodified
//   SIZE_PHYS_LOG     7  physical register tag width
//   SIZE_AL_LOG       7  active-list tag width
//   SIZE_CTI_MASK     8  branch-dependence mask width (one bit per in-flight CTI)
// PORTS
//   clk              in   1   clock
//   reset            in   1   synchronous, active-high reset
//   valid_i          in   1   ALU output valid this cycle
//   result_i         in   SIZE_DATA        ALU result_o
//   flags_i          in   EXECUTION_FLAGS  ALU flags_o
//   phyDest_i        in   SIZE_PHYS_LOG    destination physical register
//   writesReg_i      in   1   instruction writes a register
//   alTag_i          in   SIZE_AL_LOG      active-list index
//   brMask_i         in   SIZE_CTI_MASK    CTIs this instruction depends on
//   ready_o          out  1   stage can accept (count<2); upstream issue stalls when 0
//   exceptionFlush_i in   1   kill everything, including valid_i this cycle
//   ctiMispredict_i  in   1   kill entries with (brMask & ctiMask_i)!=0
//   ctiResolve_i     in   1   CTI resolved correct: clear ctiMask_i bits in all masks
//   ctiMask_i        in   SIZE_CTI_MASK    one-hot CTI being killed/resolved
//   wbReady_i        in   1   RF write port granted to this lane
//   valid_o          out  1   head entry valid and not being killed this cycle
//   result_o / flags_o / phyDest_o / writesReg_o / alTag_o  out  head entry fields
//   bypassValid_o    out  1   valid_o & writesReg_o
//   bypassTag_o      out  SIZE_PHYS_LOG    = phyDest_o
//   bypassData_o     out  SIZE_DATA        = result_o
// BEHAVIOUR
//   - Reset: count=0. valid_o, bypassValid_o = 0; all data outputs = 0; ready_o = 1
//     from the cycle after reset.
//   - Push occurs when valid_i & ready_o & ~exceptionFlush_i, and the incoming entry is not
//     killed (ctiMispredict_i & |(brMask_i & ctiMask_i)). Pop occurs when valid_o & wbReady_i.
//   - Latency: an entry accepted in cycle N is presented on valid_o in cycle N+1. There is
//     no combinational pass-through from valid_i to valid_o.
//   - ready_o is a function of registered count only: ready_o = (count!=2).
//   - Order is FIFO: head=slot0, skid=slot1. Push and pop in the same cycle with count=1:
//     the new entry becomes head and count stays 1. Pop with count=2 shifts slot1 into slot0.
//   - Priority, highest first: reset > exceptionFlush_i (count<=0 next cycle;
//     valid_o forced 0 this cycle) > mispredict kill > resolve clear > push/pop.
//   - Mispredict:
//     - Kill test: kill if (mask & ctiMask_i)!=0. It applies to both slots and to the incoming entry.
//     - valid_o is masked combinationally when the head is killed in the same cycle, so a
//       killed entry is never written.
//     - Survivors compact toward slot0; slot1 may survive while slot0 dies.
//   - Resolve: mask <= mask & ~ctiMask_i on stored and incoming entries. Entries are
//     not killed.
//   - ctiMispredict_i & ctiResolve_i asserted together is illegal. Assert it in simulation.
//   - flags pass through unchanged: bit2 executed, bit1 exception, bit0 mispredict.
//   - Stall (wbReady_i=0): head and all outputs hold stable until popped or killed.
//   - valid_i while ready_o=0 is a protocol error by the upstream stage. Drop the entry
//     and assert in simulation.
// TESTING
//   - reset, then push ADD result 0x0000_0005, dest 12, wbReady_i=1 -> valid_o=1 next cycle,
//     bypassTag_o=12, bypassData_o=5; popped; valid_o=0 after.
//   - wbReady_i=0, 3 back-to-back pushes A,B,C -> A,B accepted, ready_o=0 after 2nd, C held
//     upstream; wbReady_i=1 -> A,B,C emerge in order, one per cycle.
//   - count=2, slot0 mask=8'h01, slot1 mask=8'h02, mispredict ctiMask_i=8'h01 -> valid_o=0
//     that cycle, next cycle slot1 entry on head, count=1.
//   - incoming brMask_i=8'h04 with same-cycle mispredict ctiMask_i=8'h04 -> not stored,
//     count unchanged; resolve ctiMask_i=8'h02 on entry mask 8'h06 -> stored mask 8'h04.
//   - count=2 plus valid_i, exceptionFlush_i=1 -> valid_o=0 that cycle, count=0 next, ready_o=1.
//   - reset asserted mid-stall with count=2 -> next cycle valid_o=0, outputs 0, no write.

Source files
------------

// File: rtl/simple_alu_wb_stage.sv
// Execute->writeback pipe register for the simple-ALU lane.
// Two-entry skid queue (slot0 = head) that drains to the RF write port and
// drives the bypass network from the head. Entries are squashed on a CTI
// mispredict or an exception flush.
module simple_alu_wb_stage #(
   parameter int unsigned SIZE_DATA       = 32,
   parameter int unsigned EXECUTION_FLAGS = 6,
   parameter int unsigned SIZE_PHYS_LOG   = 7,
   parameter int unsigned SIZE_AL_LOG     = 7,
   parameter int unsigned SIZE_CTI_MASK   = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       valid_i,
   input  logic [SIZE_DATA-1:0]       result_i,
   input  logic [EXECUTION_FLAGS-1:0] flags_i,
   input  logic [SIZE_PHYS_LOG-1:0]   phyDest_i,
   input  logic                       writesReg_i,
   input  logic [SIZE_AL_LOG-1:0]     alTag_i,
   input  logic [SIZE_CTI_MASK-1:0]   brMask_i,
   output logic                       ready_o,
   input  logic                       exceptionFlush_i,
   input  logic                       ctiMispredict_i,
   input  logic                       ctiResolve_i,
   input  logic [SIZE_CTI_MASK-1:0]   ctiMask_i,
   input  logic                       wbReady_i,
   output logic                       valid_o,
   output logic [SIZE_DATA-1:0]       result_o,
   output logic [EXECUTION_FLAGS-1:0] flags_o,
   output logic [SIZE_PHYS_LOG-1:0]   phyDest_o,
   output logic                       writesReg_o,
   output logic [SIZE_AL_LOG-1:0]     alTag_o,
   output logic                       bypassValid_o,
   output logic [SIZE_PHYS_LOG-1:0]   bypassTag_o,
   output logic [SIZE_DATA-1:0]       bypassData_o
);

   typedef struct packed {
      logic [SIZE_DATA-1:0]       result;
      logic [EXECUTION_FLAGS-1:0] flags;
      logic [SIZE_PHYS_LOG-1:0]   dest;
      logic                       wr;
      logic [SIZE_AL_LOG-1:0]     al;
      logic [SIZE_CTI_MASK-1:0]   mask;
   } entry_t;

   entry_t                   r_slot [2];
   logic [1:0]               r_count;

   entry_t                   w_next_slot [2];
   logic [1:0]               w_next_count;
   entry_t                   w_in;
   entry_t                   w_res0;
   entry_t                   w_res1;
   logic [SIZE_CTI_MASK-1:0] w_keep_mask;
   logic                     w_kill0;
   logic                     w_kill1;
   logic                     w_kill_in;
   logic                     w_push;
   logic                     w_pop;
   logic                     w_keep0;
   logic                     w_keep1;

   assign ready_o   = (r_count != 2'd2);

   assign w_kill0   = ctiMispredict_i & (r_count != 2'd0) & (|(r_slot[0].mask & ctiMask_i));
   assign w_kill1   = ctiMispredict_i & (r_count == 2'd2) & (|(r_slot[1].mask & ctiMask_i));
   assign w_kill_in = ctiMispredict_i & (|(brMask_i & ctiMask_i));

   // A head being killed or flushed this cycle must never reach the RF port.
   assign valid_o   = (r_count != 2'd0) & ~exceptionFlush_i & ~w_kill0;
   assign w_pop     = valid_o & wbReady_i;
   assign w_push    = valid_i & ready_o & ~exceptionFlush_i & ~w_kill_in;

   // Surviving stored entries; a popped head does not survive.
   assign w_keep0   = (r_count != 2'd0) & ~w_kill0 & ~w_pop;
   assign w_keep1   = (r_count == 2'd2) & ~w_kill1;

   // Mispredict outranks resolve, so a resolve only clears bits when no kill is pending.
   assign w_keep_mask = (ctiResolve_i & ~ctiMispredict_i) ? ~ctiMask_i : '1;

   // Incoming and stored entries with resolved CTI bits cleared.
   always_comb begin
      w_in.result = result_i;
      w_in.flags  = flags_i;
      w_in.dest   = phyDest_i;
      w_in.wr     = writesReg_i;
      w_in.al     = alTag_i;
      w_in.mask   = brMask_i & w_keep_mask;
      w_res0      = r_slot[0];
      w_res0.mask = r_slot[0].mask & w_keep_mask;
      w_res1      = r_slot[1];
      w_res1.mask = r_slot[1].mask & w_keep_mask;
   end

   // Compact survivors toward slot0, then append the incoming entry behind them.
   always_comb begin
      w_next_slot[0] = r_slot[0];
      w_next_slot[1] = r_slot[1];
      w_next_count   = 2'd0;
      if (w_keep0) begin
         w_next_slot[0] = w_res0;
         if (w_keep1) begin
            w_next_slot[1] = w_res1;
            w_next_count   = 2'd2;
         end else if (w_push) begin
            w_next_slot[1] = w_in;
            w_next_count   = 2'd2;
         end else begin
            w_next_count   = 2'd1;
         end
      end else if (w_keep1) begin
         w_next_slot[0] = w_res1;
         if (w_push) begin
            w_next_slot[1] = w_in;
            w_next_count   = 2'd2;
         end else begin
            w_next_count   = 2'd1;
         end
      end else if (w_push) begin
         w_next_slot[0] = w_in;
         w_next_count   = 2'd1;
      end
   end

   // Queue state: reset clears contents, flush only empties the queue.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_count   <= 2'd0;
         r_slot[0] <= '0;
         r_slot[1] <= '0;
      end else if (exceptionFlush_i) begin
         r_count   <= 2'd0;
      end else begin
         r_count   <= w_next_count;
         r_slot[0] <= w_next_slot[0];
         r_slot[1] <= w_next_slot[1];
      end
   end

   assign result_o      = r_slot[0].result;
   assign flags_o       = r_slot[0].flags;
   assign phyDest_o     = r_slot[0].dest;
   assign writesReg_o   = r_slot[0].wr;
   assign alTag_o       = r_slot[0].al;
   assign bypassValid_o = valid_o & r_slot[0].wr;
   assign bypassTag_o   = r_slot[0].dest;
   assign bypassData_o  = r_slot[0].result;

`ifndef SYNTHESIS
   a_misp_resolve_exclusive : assert property (@(posedge clk) disable iff (reset)
      !(ctiMispredict_i && ctiResolve_i));
   // Upstream must not present a result while stalled; a flush discards it anyway.
   a_no_push_when_full : assert property (@(posedge clk) disable iff (reset)
      !(valid_i && !ready_o && !exceptionFlush_i));
`endif

endmodule
